// File: rtl/ins_mem_pkg.sv
// ----------------------------------------------------------------------------
// ins_mem_pkg
// Shared definitions for the instruction memory and its byte-stream loader:
//   - ld_state_e    : loader FSM state encoding (IDLE, LOAD, DONE)
//   - BYTE_CNT_W    : width of the byte-within-word counter; sized for the
//                     widest supported word (64 bits = 8 bytes)
//   - calc_bpw()    : bytes per instruction word for a given data width
// ----------------------------------------------------------------------------
package ins_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

    localparam int unsigned BYTE_CNT_W = 3;

    function automatic int unsigned calc_bpw(input int unsigned data_width);
        return data_width / 32'd8;
    endfunction

endpackage

// File: rtl/ins_mem_core.sv
// ----------------------------------------------------------------------------
// ins_mem_core
// Simple dual-port RAM: one write port, one registered read port.
// The storage array has no reset so it maps onto block RAM; only the read
// output register and its valid flag are reset.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (read register only)
//   wr_en     in   write strobe
//   wr_addr   in   write word address
//   wr_data   in   write word
//   rd_en     in   read strobe
//   rd_addr   in   read word address
//   rd_data   out  registered read word; holds when rd_en is low
//   rd_valid  out  rd_data was updated at the last edge
// ----------------------------------------------------------------------------
module ins_mem_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Write port: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port; the data register holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= {DATA_WIDTH{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= mem_q[rd_addr];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/ins_mem_loader.sv
// ----------------------------------------------------------------------------
// ins_mem_loader
// Instruction memory with an integrated byte-stream loader. Port A is the
// core's fetch port (1-cycle latency); the loader packs 8-bit handshaked
// bytes little-endian into DATA_WIDTH-bit words and writes them from word 0
// upwards. Fetch is blocked while a load is in flight.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   fetch_en       fetch request, honoured only while load_busy is low
//   fetch_addr     fetch word address
//   fetch_data     registered fetch word (holds when not fetching)
//   fetch_valid    fetch_data updated at the last edge
//   load_start     start-load pulse, only sampled in IDLE
//   load_len       number of words to load, legal 1..2**ADDR_WIDTH
//   ld_byte        stream byte
//   ld_valid       stream byte valid
//   ld_ready       loader accepts a byte (high in LOAD)
//   load_busy      load in flight (high in LOAD)
//   load_done      one-cycle completion pulse
//   load_err       one-cycle pulse for an illegal load_len
//   words_loaded   words written by the current or last load
// ----------------------------------------------------------------------------
module ins_mem_loader
    import ins_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned BPW   = calc_bpw(DATA_WIDTH);
    localparam int unsigned LEN_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [LEN_W-1:0]      DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BPW - 1);

    ld_state_e             state_q;
    logic [LEN_W-1:0]      len_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [BYTE_CNT_W-1:0] byte_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [LEN_W-1:0]      words_loaded_q;
    logic                  ld_ready_q;
    logic                  load_busy_q;
    logic                  load_done_q;
    logic                  load_err_q;

    logic [DATA_WIDTH-1:0] pack_d;
    logic                  accept_s;
    logic                  last_byte_s;
    logic                  len_ok_s;
    logic                  wr_en_s;
    logic                  rd_en_s;

    // Handshake and word-completion qualifiers.
    always_comb begin
        accept_s    = ld_valid && ld_ready_q;
        last_byte_s = (byte_cnt_q == LAST_BYTE);
        len_ok_s    = (load_len != {LEN_W{1'b0}}) && (load_len <= DEPTH_LEN);
        // The final byte is merged combinationally so the complete word is
        // written on the same edge it is accepted.
        wr_en_s     = accept_s && last_byte_s && !rst;
        rd_en_s     = fetch_en && !load_busy_q;
    end

    // Packer: drop the incoming byte into its little-endian lane.
    always_comb begin
        pack_d = shift_q;
        for (int unsigned b = 0; b < BPW; b++) begin
            pack_d[b*8 +: 8] = (byte_cnt_q == BYTE_CNT_W'(b)) ? ld_byte
                                                              : shift_q[b*8 +: 8];
        end
    end

    // Loader FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            len_q          <= {LEN_W{1'b0}};
            ptr_q          <= {ADDR_WIDTH{1'b0}};
            byte_cnt_q     <= {BYTE_CNT_W{1'b0}};
            shift_q        <= {DATA_WIDTH{1'b0}};
            words_loaded_q <= {LEN_W{1'b0}};
            ld_ready_q     <= 1'b0;
            load_busy_q    <= 1'b0;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
        end else begin
            load_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        if (len_ok_s) begin
                            len_q          <= load_len;
                            ptr_q          <= {ADDR_WIDTH{1'b0}};
                            byte_cnt_q     <= {BYTE_CNT_W{1'b0}};
                            words_loaded_q <= {LEN_W{1'b0}};
                            ld_ready_q     <= 1'b1;
                            load_busy_q    <= 1'b1;
                            state_q        <= ST_LOAD;
                        end else begin
                            load_err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // load_start is deliberately not looked at here.
                    if (accept_s) begin
                        shift_q <= pack_d;
                        if (last_byte_s) begin
                            byte_cnt_q     <= {BYTE_CNT_W{1'b0}};
                            ptr_q          <= ptr_q + ADDR_WIDTH'(1);
                            words_loaded_q <= words_loaded_q + LEN_W'(1);
                            if ((words_loaded_q + LEN_W'(1)) == len_q) begin
                                ld_ready_q  <= 1'b0;
                                load_busy_q <= 1'b0;
                                load_done_q <= 1'b1;
                                state_q     <= ST_DONE;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    load_done_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    ld_ready_q  <= 1'b0;
                    load_busy_q <= 1'b0;
                    load_done_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    ins_mem_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_s),
        .wr_addr  (ptr_q),
        .wr_data  (pack_d),
        .rd_en    (rd_en_s),
        .rd_addr  (fetch_addr),
        .rd_data  (fetch_data),
        .rd_valid (fetch_valid)
    );

    assign ld_ready     = ld_ready_q;
    assign load_busy    = load_busy_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
module tb_ins_mem_loader;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int BPW   = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] fetch_data;
    logic          fetch_valid;
    logic          load_start;
    logic [AW:0]   load_len;
    logic [7:0]    ld_byte;
    logic          ld_valid;
    logic          ld_ready;
    logic          load_busy;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    int total = 0;
    int bad   = 0;

    // Reference image of the memory: what each word should hold, and
    // whether it has been written at all since time zero.
    logic [DW-1:0] model_mem [DEPTH];
    bit            known     [DEPTH];
    logic [DW-1:0] last_fetch;

    ins_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .fetch_addr   (fetch_addr),
        .fetch_data   (fetch_data),
        .fetch_valid  (fetch_valid),
        .load_start   (load_start),
        .load_len     (load_len),
        .ld_byte      (ld_byte),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fdata"}, fetch_data, '0);
        chk({tag, "_fvalid"}, fetch_valid, 1'b0);
        chk({tag, "_ready"}, ld_ready, 1'b0);
        chk({tag, "_busy"}, load_busy, 1'b0);
        chk({tag, "_done"}, load_done, 1'b0);
        chk({tag, "_err"}, load_err, 1'b0);
        chk({tag, "_wl"}, words_loaded, '0);
    endtask

    task automatic fetch_one(input int addr, input logic [DW-1:0] exp);
        fetch_en   = 1'b1;
        fetch_addr = AW'(addr);
        tick();
        fetch_en = 1'b0;
        chk("fetch_one_v", fetch_valid, 1'b1);
        chk("fetch_one_d", fetch_data, exp);
        last_fetch = exp;
    endtask

    // Back-to-back fetch of words 0..n-1, then one idle cycle.
    task automatic fetch_sweep(input int n);
        for (int i = 0; i < n; i++) begin
            fetch_en   = 1'b1;
            fetch_addr = AW'(i);
            tick();
            chk("sweep_v", fetch_valid, 1'b1);
            chk("sweep_d", fetch_data, model_mem[i]);
            last_fetch = model_mem[i];
        end
        fetch_en = 1'b0;
        tick();
        chk("sweep_idle_v", fetch_valid, 1'b0);
        chk("sweep_idle_d", fetch_data, last_fetch);
    endtask

    task automatic bad_len(input int len);
        load_len   = (AW+1)'(len);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("err_pulse", load_err, 1'b1);
        chk("err_busy", load_busy, 1'b0);
        chk("err_ready", ld_ready, 1'b0);
        tick();
        chk("err_once", load_err, 1'b0);
        chk("err_busy2", load_busy, 1'b0);
    endtask

    // One complete load. gap: cycles of ld_valid low before every byte but
    // the first (fixed, or random 0..gap when rand_gap). directed bytes are
    // 1,2,3,...; stray issues a second load_start mid-load.
    task automatic run_load(input int len, input int gap, input bit rand_gap,
                            input bit directed, input bit stray);
        int            nbytes;
        int            g;
        int            fa;
        bit            fe;
        logic [7:0]    b;
        logic [DW-1:0] acc;
        nbytes = len * BPW;
        acc    = '0;
        fa     = $urandom_range(0, DEPTH - 1);
        fe     = known[fa];
        // Fetch in the start cycle must still be served; junk on the
        // stream while IDLE must not be consumed.
        fetch_en   = fe;
        fetch_addr = AW'(fa);
        ld_valid   = 1'b1;
        ld_byte    = 8'hEE;
        load_len   = (AW+1)'(len);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        fetch_en   = 1'b0;
        ld_valid   = 1'b0;
        chk("ready_rise", ld_ready, 1'b1);
        chk("busy_rise", load_busy, 1'b1);
        chk("wl_clear", words_loaded, '0);
        if (fe) begin
            chk("start_fetch_v", fetch_valid, 1'b1);
            chk("start_fetch_d", fetch_data, model_mem[fa]);
            last_fetch = model_mem[fa];
        end else begin
            chk("start_nofetch_v", fetch_valid, 1'b0);
        end
        for (int idx = 0; idx < nbytes; idx++) begin
            g = 0;
            if (idx > 0) g = rand_gap ? $urandom_range(0, gap) : gap;
            for (int k = 0; k < g; k++) begin
                ld_valid   = 1'b0;
                fetch_en   = 1'($urandom_range(0, 1));
                fetch_addr = AW'($urandom_range(0, DEPTH - 1));
                tick();
                chk("gap_fetch_v", fetch_valid, 1'b0);
                chk("gap_fetch_d", fetch_data, last_fetch);
                chk("gap_wl", words_loaded, idx / BPW);
                chk("gap_done", load_done, 1'b0);
            end
            b = directed ? 8'(idx + 1) : 8'($urandom);
            chk("ready_on", ld_ready, 1'b1);
            ld_byte    = b;
            ld_valid   = 1'b1;
            fetch_en   = 1'($urandom_range(0, 1));
            fetch_addr = AW'($urandom_range(0, DEPTH - 1));
            if (stray && idx == nbytes / 2) begin
                load_start = 1'b1;
                load_len   = (AW+1)'($urandom_range(0, 31));
            end
            tick();
            ld_valid   = 1'b0;
            load_start = 1'b0;
            fetch_en   = 1'b0;
            acc = acc | (DW'(b) << (8 * (idx % BPW)));
            if (idx % BPW == BPW - 1) begin
                model_mem[idx / BPW] = acc;
                known[idx / BPW]     = 1'b1;
                acc                  = '0;
            end
            chk("byte_wl", words_loaded, (idx + 1) / BPW);
            chk("byte_fetch_v", fetch_valid, 1'b0);
            chk("byte_fetch_d", fetch_data, last_fetch);
            chk("byte_err", load_err, 1'b0);
            if (idx < nbytes - 1) begin
                chk("byte_busy", load_busy, 1'b1);
                chk("byte_done", load_done, 1'b0);
            end
        end
        chk("done_pulse", load_done, 1'b1);
        chk("ready_fall", ld_ready, 1'b0);
        chk("busy_fall", load_busy, 1'b0);
        tick();
        chk("done_once", load_done, 1'b0);
        chk("ready_idle", ld_ready, 1'b0);
        chk("wl_final", words_loaded, len);
    endtask

    initial begin
        rst        = 1'b1;
        fetch_en   = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_len   = '0;
        ld_byte    = '0;
        ld_valid   = 1'b0;
        last_fetch = '0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_reset_outputs("reset");

        // Directed image, back-to-back.
        run_load(2, 0, 1'b0, 1'b1, 1'b0);
        fetch_one(0, 32'h0403_0201);
        fetch_one(1, 32'h0807_0605);

        // Same image with 3-cycle gaps between bytes.
        run_load(2, 3, 1'b0, 1'b1, 1'b0);
        fetch_sweep(2);

        // Illegal lengths leave memory and fetch path alone.
        bad_len(0);
        bad_len(DEPTH + 1);
        fetch_one(0, 32'h0403_0201);

        // Full-depth load with random gaps and a stray load_start.
        run_load(DEPTH, 2, 1'b1, 1'b0, 1'b1);
        fetch_sweep(DEPTH);

        // Reset after one full word plus one byte of a 4-word load.
        load_len   = (AW+1)'(4);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < BPW + 1; i++) begin
            ld_byte  = 8'(8'hA0 + i);
            ld_valid = 1'b1;
            tick();
        end
        ld_valid     = 1'b0;
        model_mem[0] = 32'hA3A2_A1A0;
        chk("midload_wl", words_loaded, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        last_fetch = '0;
        fetch_one(0, 32'hA3A2_A1A0);
        fetch_one(1, model_mem[1]);

        // New load of one word overwrites word 0 only.
        run_load(1, 0, 1'b0, 1'b1, 1'b0);
        fetch_one(0, 32'h0403_0201);
        fetch_one(1, model_mem[1]);

        // Random loads.
        for (int r = 0; r < 6; r++) begin
            run_load($urandom_range(1, DEPTH), 2, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
            fetch_sweep(DEPTH);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
